// File: rtl/fetch_unit.sv
// Instruction fetch unit: launches one of three programs, streams instruction words downstream.
// Optional build macro FETCH_JUMP_EN enables in-fetch decoding of jump words (opcode 6'b010000).
module fetch_unit #(
    parameter logic [9:0] PROG0_BASE = 10'd1,
    parameter logic [9:0] PROG1_BASE = 10'd25,
    parameter logic [9:0] PROG2_BASE = 10'd35,
    parameter logic [9:0] MEM_LAST   = 10'd80
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  prog_sel,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [9:0]  branch_target,
    input  logic        halt_req,
    input  logic [31:0] instrucao,
    output logic [9:0]  address,
    output logic [31:0] instr_out,
    output logic        instr_valid,
    output logic        busy,
    output logic        fault
);

    typedef enum logic [1:0] {StIdle, StFetch, StHalt} state_e;

    state_e state;

    logic [9:0] sel_base;
    logic       sel_legal;

    always_comb begin
        sel_base  = PROG0_BASE;
        sel_legal = 1'b1;
        case (prog_sel)
            2'd0:    sel_base = PROG0_BASE;
            2'd1:    sel_base = PROG1_BASE;
            2'd2:    sel_base = PROG2_BASE;
            default: sel_legal = 1'b0;
        endcase
    end

    logic       jump_hit;
    logic [9:0] jump_target;

    assign jump_target = instrucao[9:0];
`ifdef FETCH_JUMP_EN
    assign jump_hit = (instrucao[31:26] == 6'b010000);
`else
    assign jump_hit = 1'b0;
`endif

    logic branch_bad;
    logic jump_bad;
    logic at_last;

    assign branch_bad = (branch_target > MEM_LAST);
    assign jump_bad   = (jump_target > MEM_LAST);
    assign at_last    = (address >= MEM_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= StIdle;
            address     <= 10'd0;
            instr_out   <= 32'd0;
            instr_valid <= 1'b0;
            fault       <= 1'b0;
        end else begin
            case (state)
                StIdle, StHalt: begin
                    instr_valid <= 1'b0;
                    if (start) begin
                        if (sel_legal) begin
                            address <= sel_base;
                            state   <= StFetch;
                        end else begin
                            fault <= 1'b1;
                        end
                    end
                end
                StFetch: begin
                    if (halt_req) begin
                        instr_valid <= 1'b0;
                        state       <= StHalt;
                    end else if (branch_taken) begin
                        // Redirect always costs one bubble, even under stall.
                        instr_valid <= 1'b0;
                        if (branch_bad) begin
                            fault <= 1'b1;
                            state <= StHalt;
                        end else begin
                            address <= branch_target;
                        end
                    end else if (!stall) begin
                        instr_out   <= instrucao;
                        instr_valid <= 1'b1;
                        if (jump_hit) begin
                            if (jump_bad) begin
                                fault <= 1'b1;
                                state <= StHalt;
                            end else begin
                                address <= jump_target;
                            end
                        end else if (at_last) begin
                            // Last word is still issued; PC never moves past MEM_LAST.
                            fault <= 1'b1;
                            state <= StHalt;
                        end else begin
                            address <= address + 10'd1;
                        end
                    end
                end
                default: begin
                    state       <= StIdle;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

    assign busy = (state == StFetch);

endmodule
